// File: rtl/score_combo_tracker_pkg.sv
// Shared game definitions: decoded game-state codes, default combo step and
// score width, used by the scoring stage and the game-state generator.
package score_combo_tracker_pkg;

   localparam logic [1:0] GS_BEGIN = 2'd0;
   localparam logic [1:0] GS_PAUSE = 2'd1;
   localparam logic [1:0] GS_RESET = 2'd2;

   localparam int unsigned COMBO_STEP_DEF = 5;
   localparam int unsigned BCD_DIGITS     = 4;
   localparam int unsigned SCORE_W        = 4 * BCD_DIGITS;

endpackage

// File: rtl/score_combo_tracker_bcd_add_sat.sv
// Combinational BCD adder: score plus a small addend (1 or 2), ripple carry
// per digit, saturating at all-nines when the top digit overflows.
module bcd_add_sat
   import score_combo_tracker_pkg::*;
(
   input  logic [SCORE_W-1:0] a_i,
   input  logic [1:0]         addend_i,
   output logic [SCORE_W-1:0] sum_c
);

   logic [1:0] carry;
   logic [4:0] dig;

   always_comb begin
      carry = addend_i;
      dig   = '0;
      sum_c = '0;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         dig = 5'(a_i[4*i +: 4]) + 5'(carry);
         if (dig > 5'd9) begin
            sum_c[4*i +: 4] = 4'(dig - 5'd10);
            carry           = 2'd1;
         end else begin
            sum_c[4*i +: 4] = dig[3:0];
            carry           = 2'd0;
         end
      end
      // Carry out of the thousands digit means the score would pass 9999.
      if (carry != 2'd0) begin
         sum_c = {BCD_DIGITS{4'h9}};
      end
   end

endmodule

// File: rtl/score_combo_tracker.sv
// Scoring stage: BCD score, current/best hit streak and a one-cycle combo
// pulse every COMBO_STEP consecutive hits.
module score_combo_tracker
   import score_combo_tracker_pkg::*;
#(
   parameter int unsigned COMBO_STEP = COMBO_STEP_DEF,
   parameter int unsigned STREAK_MAX = 99
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         game_state,
   input  logic               hit,
   input  logic               miss,
   output logic [SCORE_W-1:0] score_bcd,
   output logic [6:0]         streak,
   output logic [6:0]         best_streak,
   output logic               combo
);

   localparam int unsigned    STEP_W    = (COMBO_STEP > 1) ? $clog2(COMBO_STEP) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(COMBO_STEP - 1);
   localparam logic [6:0]     STREAK_TOP = 7'(STREAK_MAX);
   localparam logic [6:0]     BONUS_AT   = 7'(COMBO_STEP);

   logic [SCORE_W-1:0] score_q, score_d;
   logic [6:0]         streak_q, streak_d;
   logic [6:0]         best_q, best_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic               combo_q, combo_d;

   logic [1:0]         addend;
   logic [SCORE_W-1:0] score_inc_c;

   assign addend = (streak_q >= BONUS_AT) ? 2'd2 : 2'd1;

   bcd_add_sat u_bcd_add_sat (
      .a_i      (score_q),
      .addend_i (addend),
      .sum_c    (score_inc_c)
   );

   // Next-state: RESET clears the run, PAUSE/3 holds, BEGIN scores hits/misses.
   always_comb begin
      score_d  = score_q;
      streak_d = streak_q;
      best_d   = best_q;
      step_d   = step_q;
      combo_d  = 1'b0;
      case (game_state)
         GS_RESET: begin
            score_d  = '0;
            streak_d = '0;
            step_d   = '0;
         end
         GS_BEGIN: begin
            if (miss) begin
               streak_d = '0;
               step_d   = '0;
            end else if (hit) begin
               score_d = score_inc_c;
               if (streak_q != STREAK_TOP) begin
                  streak_d = streak_q + 7'd1;
                  if (step_q == STEP_LAST) begin
                     step_d  = '0;
                     combo_d = 1'b1;
                  end else begin
                     step_d = step_q + STEP_W'(1);
                  end
               end
               if (streak_d > best_q) begin
                  best_d = streak_d;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         score_q  <= '0;
         streak_q <= '0;
         best_q   <= '0;
         step_q   <= '0;
         combo_q  <= 1'b0;
      end else begin
         score_q  <= score_d;
         streak_q <= streak_d;
         best_q   <= best_d;
         step_q   <= step_d;
         combo_q  <= combo_d;
      end
   end

   assign score_bcd   = score_q;
   assign streak      = streak_q;
   assign best_streak = best_q;
   assign combo       = combo_q;

endmodule

// File: tb/tb_score_combo_tracker.sv
// Bench for score_combo_tracker: decimal-arithmetic reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_score_combo_tracker;

   localparam int STEP = 5;
   localparam int SMAX = 99;

   logic        clk;
   logic        rst;
   logic [1:0]  game_state;
   logic        hit;
   logic        miss;
   logic [15:0] score_bcd;
   logic [6:0]  streak;
   logic [6:0]  best_streak;
   logic        combo;

   int errors = 0;
   int checks = 0;
   bit en_cmp = 0;

   int m_score  = 0;
   int m_streak = 0;
   int m_best   = 0;
   int m_combo  = 0;

   score_combo_tracker #(.COMBO_STEP(STEP), .STREAK_MAX(SMAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .game_state  (game_state),
      .hit         (hit),
      .miss        (miss),
      .score_bcd   (score_bcd),
      .streak      (streak),
      .best_streak (best_streak),
      .combo       (combo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain decimal score, streak, best, combo from the rules.
   always @(posedge clk) begin
      m_combo = 0;
      if (rst) begin
         m_score = 0; m_streak = 0; m_best = 0;
      end else if (game_state == 2'd2) begin
         m_score = 0; m_streak = 0;
      end else if (game_state == 2'd0) begin
         if (miss) begin
            m_streak = 0;
         end else if (hit) begin
            m_score = m_score + ((m_streak >= STEP) ? 2 : 1);
            if (m_score > 9999) m_score = 9999;
            if (m_streak < SMAX) begin
               m_streak = m_streak + 1;
               if (m_streak % STEP == 0) m_combo = 1;
            end
            if (m_streak > m_best) m_best = m_streak;
         end
      end
   end

   // Per-cycle comparison against the model, plus BCD digit sanity.
   always @(negedge clk) begin
      if (en_cmp) begin
         check("model_score",  32'(score_bcd),   32'(to_bcd(m_score)));
         check("model_streak", 32'(streak),      32'(m_streak));
         check("model_best",   32'(best_streak), 32'(m_best));
         check("model_combo",  32'(combo),       32'(m_combo));
         for (int d = 0; d < 4; d++) begin
            if (score_bcd[4*d +: 4] > 4'd9) begin
               errors++;
               $display("FAIL bcd_digit%0d: got %0d expected <=9", d, score_bcd[4*d +: 4]);
            end
         end
      end
   end

   task automatic cyc(input logic r, input logic [1:0] gs, input logic h, input logic m);
      rst = r; game_state = gs; hit = h; miss = m;
      @(negedge clk);
   endtask

   int pulses;
   int guard;

   initial begin
      rst = 1'b1; game_state = 2'd1; hit = 1'b0; miss = 1'b0;
      cyc(1, 2'd1, 0, 0);
      cyc(1, 2'd1, 0, 0);
      check("rst_score",  32'(score_bcd),   32'h0);
      check("rst_streak", 32'(streak),      32'h0);
      check("rst_best",   32'(best_streak), 32'h0);
      check("rst_combo",  32'(combo),       32'h0);
      en_cmp = 1;

      repeat (3) cyc(0, 2'd1, 1, 0);
      check("pause_streak", 32'(streak),    32'h0);
      check("pause_score",  32'(score_bcd), 32'h0);

      for (int i = 1; i <= 5; i++) begin
         cyc(0, 2'd0, 1, 0);
         if (i < 5) check("combo_early", 32'(combo), 32'h0);
      end
      check("five_streak", 32'(streak),    32'd5);
      check("five_score",  32'(score_bcd), 32'h0005);
      check("five_combo",  32'(combo),     32'h1);
      cyc(0, 2'd0, 1, 0);
      check("combo_one_cycle", 32'(combo), 32'h0);
      cyc(0, 2'd0, 1, 0);
      check("seven_streak", 32'(streak),    32'd7);
      check("seven_score",  32'(score_bcd), 32'h0009);
      check("seven_combo",  32'(combo),     32'h0);

      cyc(0, 2'd0, 1, 1);
      check("miss_streak", 32'(streak),      32'd0);
      check("miss_best",   32'(best_streak), 32'd7);
      check("miss_score",  32'(score_bcd),   32'h0009);

      // State 3 behaves as PAUSE.
      cyc(0, 2'd3, 1, 0);
      check("gs3_streak", 32'(streak), 32'd0);

      // A hit coincident with RESET is discarded.
      cyc(0, 2'd0, 1, 0);
      cyc(0, 2'd2, 1, 0);
      cyc(0, 2'd0, 0, 0);
      check("gsreset_score",  32'(score_bcd),   32'h0);
      check("gsreset_streak", 32'(streak),      32'd0);
      check("gsreset_best",   32'(best_streak), 32'd7);

      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(0, 2'd0, 1, 0);
         if (combo) pulses++;
      end
      check("run100_streak", 32'(streak),      32'd99);
      check("run100_best",   32'(best_streak), 32'd99);
      check("run100_score",  32'(score_bcd),   32'h0195);
      check("run100_pulses", 32'(pulses),      32'd19);

      guard = 0;
      while (score_bcd != 16'h9999 && guard < 6000) begin
         cyc(0, 2'd0, 1, 0);
         guard++;
      end
      check("reach_9999_in_budget", 32'(guard < 6000), 32'h1);
      repeat (3) cyc(0, 2'd0, 1, 0);
      check("sat_score",  32'(score_bcd), 32'h9999);
      check("sat_streak", 32'(streak),    32'd99);

      cyc(0, 2'd1, 0, 0);
      en_cmp = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_combo_tracker.md
# score_combo_tracker

Scoring stage of the rhythm game, directly upstream of the game-state generator. Consumes the decoded game state (begin/pause/reset) and per-press hit/miss events. Maintains a 4-digit BCD score, the current hit streak and the best streak. Emits the single-cycle `combo` pulse that the state generator stretches into its combo-display enable.

## Interface
Parameters:
- `COMBO_STEP`, 5: streak multiple that fires `combo`; also the bonus threshold.
- `STREAK_MAX`, 99: saturation value of the streak counters (two display digits).

Ports:
- `clk`, in, 1: system clock; single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `game_state`, in, 2: 0 = BEGIN, 1 = PAUSE, 2 = RESET; value 3 is treated as PAUSE.
- `hit`, in, 1: one-cycle pulse for a correct press.
- `miss`, in, 1: one-cycle pulse for a wrong or late press.
- `score_bcd`, out, 16: four BCD digits, `[15:12]` is the thousands digit.
- `streak`, out, 7: current consecutive hits, binary.
- `best_streak`, out, 7: maximum streak since `rst`, binary.
- `combo`, out, 1: one-cycle pulse.

## Operation
- `rst`: `score_bcd`=0, `streak`=0, `best_streak`=0, `combo`=0, internal step counter=0.
- `game_state`=RESET: clear score, streak, step counter and `combo`. `best_streak` is retained.
- PAUSE (or 3): all registers hold, `hit`/`miss` ignored, `combo`=0.
- BEGIN, valid hit (`hit`=1, `miss`=0):
  - Score increment = 2 if the pre-increment streak ≥ `COMBO_STEP`, else 1.
  - Streak increments unless already at `STREAK_MAX`.
  - `best_streak` = max(`best_streak`, new streak).
- BEGIN, `miss`=1 (with or without `hit`; miss wins): streak=0, step counter=0, score unchanged.
- Combo detection uses a mod-`COMBO_STEP` step counter, not division.
  - The step counter advances only when the streak actually increments.
  - `combo` fires on the increment that wraps the counter to 0, i.e. when the new streak is a nonzero multiple of `COMBO_STEP`.
  - Once the streak is held at `STREAK_MAX`, neither the step counter nor `combo` changes.
- Score arithmetic is BCD with per-digit carry (digit > 9 → subtract 10, carry 1). If the result would exceed 9999, the score holds at 9999.

## Timing
- All outputs are registered. The event in cycle N is visible on the outputs at N+1.
- `combo` is high for exactly cycle N+1 after the qualifying hit, then low. Back-to-back qualifying pulses cannot occur when `COMBO_STEP` ≥ 2.
- Priority within a cycle: `rst` > `game_state`=RESET > PAUSE > miss > hit.
- A `game_state` change takes effect in the same cycle it is sampled. A hit coincident with a RESET cycle is discarded.
- No handshake: `hit`/`miss` are assumed already debounced single-cycle pulses. Holding `hit` high counts one hit per cycle.

## Structure
- Shared game package:
  - state constants GS_BEGIN=2'd0, GS_PAUSE=2'd1, GS_RESET=2'd2;
  - default `COMBO_STEP`;
  - BCD digit count (4).
  The state generator uses the same package.
- One sub-module, `bcd_add_sat`: 4-digit BCD plus a 2-bit addend (1 or 2), combinational, saturating at 9999. Instanced once.
- Remaining logic (streak, step counter, best, combo register) lives in the top module.

## Test plan
- Assert `rst` 2 cycles → all outputs 0. Release in PAUSE, pulse `hit` ×3 → outputs unchanged.
- BEGIN, 5 hits on consecutive cycles:
  - `streak`=5, `score_bcd`=16'h0005;
  - `combo` high exactly one cycle, the cycle after the 5th hit.
- Continue with 2 hits → `streak`=7, `score_bcd`=16'h0009, no `combo`. Then `hit`+`miss` in the same cycle → `streak`=0, `best_streak`=7, score stays 16'h0009.
- `game_state`=RESET one cycle, then BEGIN → `score_bcd`=0, `streak`=0, `best_streak`=7.
- From reset, 100 consecutive hits:
  - `streak`=99, `best_streak`=99, `score_bcd`=16'h0195;
  - exactly 19 `combo` pulses (streak 5, 10, …, 95).
- Drive hits until the score reaches 16'h9999, then 3 more hits → score holds 16'h9999 and no digit exceeds 9.
